voting_machine_param: RTL and testbench
=======================================

VOTING_MACHINE_PARAM -- requirements
Module: voting_machine_param

Interface
REQ-001 SHALL have parameter N_CAND, default 3, number of candidate buttons/counters (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of every vote counter.
REQ-003 SHALL have parameter LOCKOUT_CYC, default 4, post-vote ignore window in clk cycles (used only with VOTE_LOCKOUT_EN).
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn  in  N_CAND  raw asynchronous candidate buttons, bit i = candidate i.
REQ-007 SHALL have port open_poll  in  1  synchronous request to open a session.
REQ-008 SHALL have port close_poll  in  1  synchronous request to close a session.
REQ-009 SHALL have port counts  out  N_CAND*CNT_W  candidate i count at bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port invalid_cnt  out  CNT_W  number of rejected multi-button votes.
REQ-011 SHALL have port vote_ack  out  1  one-cycle pulse per accepted single-candidate vote.
REQ-012 SHALL have port state  out  2  session state: IDLE=00, OPEN=01, CLOSED=10.
REQ-013 SHALL have port winner  out  clog2(N_CAND)  winning candidate index.
REQ-014 SHALL have port tie  out  1  tie between two or more leading candidates.

Function
REQ-015 SHALL pass each btn bit through a 2-flop synchroniser, then rising-edge detect into press vector p.
REQ-016 SHALL register a count change on the 3rd rising clk edge at which btn is high; a held button counts once.
REQ-017 SHALL accept a vote only in OPEN with exactly one bit of p set: that counter +1, vote_ack=1 next cycle.
REQ-018 SHALL, in OPEN with two or more bits of p set, leave all candidate counts unchanged, increment invalid_cnt, keep vote_ack=0.
REQ-019 SHALL ignore all presses in IDLE and CLOSED.
REQ-020 SHALL saturate each counter (including invalid_cnt) at 2^CNT_W-1; a vote to a saturated candidate still pulses vote_ack.
REQ-021 FSM transitions: IDLE->OPEN on open_poll; OPEN->CLOSED on close_poll; CLOSED->OPEN on open_poll, clearing all counts and invalid_cnt in that same edge.
REQ-022 In OPEN, close_poll SHALL take priority over open_poll; open_poll in OPEN and close_poll in IDLE/CLOSED SHALL be ignored.
REQ-023 A press evaluated in the same cycle as close_poll SHALL be counted (evaluation uses pre-transition state OPEN).
REQ-024 In CLOSED, winner SHALL be the lowest index holding the maximum count; tie=1 iff that maximum is nonzero and held by two or more candidates.
REQ-025 Outside CLOSED, and in CLOSED with all counts zero, winner=0 and tie=0.
REQ-026 winner/tie SHALL derive combinationally from registered counts and state (no added latency).

Reset
REQ-027 rst low SHALL immediately force state=IDLE, all counts=0, invalid_cnt=0, vote_ack=0, synchroniser/edge flops=0, lockout timer=0.
REQ-028 Reset asserted mid-session SHALL discard all votes; a button held through reset release SHALL not register a press until released and re-pressed.

Configuration
REQ-029 Macro VOTE_LOCKOUT_EN defined: after any evaluated press (valid or invalid) in OPEN, p SHALL be ignored for the next LOCKOUT_CYC cycles.
REQ-030 Macro VOTE_LOCKOUT_EN undefined: no lockout; presses on consecutive cycles are each evaluated; LOCKOUT_CYC unused.

Verification
REQ-031 Reset, open_poll, press btn[0] -> counts[0]=1 three edges later, vote_ack one-cycle pulse, others 0.
REQ-032 OPEN, btn[0] and btn[2] rise same cycle -> counts unchanged, invalid_cnt=1, vote_ack stays 0.
REQ-033 btn[1] held high 10 cycles -> counts[1] increments exactly once.
REQ-034 CNT_W=4 instance, 17 separate btn[1] presses -> counts[1]=15, 17 vote_ack pulses.
REQ-035 Votes {2,2,1}, close_poll -> state=CLOSED, winner=0, tie=1; further btn[2] press leaves counts[2]=1; open_poll -> all counts 0, state OPEN.
REQ-036 rst pulsed low mid-OPEN with counts {3,1,0} -> all counts 0, state IDLE immediately; with VOTE_LOCKOUT_EN, presses on btn[0] two cycles apart -> counts[0]=1.

Source files
------------

// File: rtl/voting_machine_param.sv
// rtl/voting_machine_param.sv - parameterised poll-session voting machine with per-candidate counters
// Optional post-vote lockout window is enabled by defining VOTE_LOCKOUT_EN.
module voting_machine_param #(
  parameter int N_CAND      = 3,
  parameter int CNT_W       = 8,
  parameter int LOCKOUT_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CAND-1:0]          btn,
  input  logic                       open_poll,
  input  logic                       close_poll,
  output logic [N_CAND*CNT_W-1:0]    counts,
  output logic [CNT_W-1:0]           invalid_cnt,
  output logic                       vote_ack,
  output logic [1:0]                 state,
  output logic [$clog2(N_CAND)-1:0]  winner,
  output logic                       tie
);

  localparam int WIN_W = $clog2(N_CAND);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_CLOSED = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [N_CAND-1:0]       sync1_q, sync2_q, prev_q;
  logic [1:0]              warm_q;
  logic [N_CAND*CNT_W-1:0] counts_q, counts_d;
  logic [CNT_W-1:0]        inv_q, inv_d;
  logic                    ack_q, ack_d;
  logic [N_CAND-1:0]       press;
  logic                    locked;
  logic                    eval;

`ifdef VOTE_LOCKOUT_EN
  localparam int LK_W = $clog2(LOCKOUT_CYC + 2);
  logic [LK_W-1:0] lock_q, lock_d;

  assign locked = (lock_q != '0);

  always_comb begin
    lock_d = lock_q;
    if (eval) begin
      lock_d = LK_W'(LOCKOUT_CYC);
    end else if (locked) begin
      lock_d = lock_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign locked = 1'b0;
`endif

  // Edges are masked until the synchroniser has refilled after reset, so a
  // button held through reset release is not mistaken for a fresh press.
  assign press = sync2_q & ~prev_q & {N_CAND{(warm_q == 2'd3) && !locked}};
  assign eval  = (state_q == ST_OPEN) && (|press);

  always_comb begin
    state_d  = state_q;
    counts_d = counts_q;
    inv_d    = inv_q;
    ack_d    = 1'b0;

    if (eval) begin
      if ($onehot(press)) begin
        ack_d = 1'b1;
        for (int i = 0; i < N_CAND; i++) begin
          if (press[i] && (counts_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
            counts_d[i*CNT_W +: CNT_W] = counts_q[i*CNT_W +: CNT_W] + 1'b1;
          end
        end
      end else if (inv_q != CNT_MAX) begin
        inv_d = inv_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (open_poll) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (close_poll) state_d = ST_CLOSED;
      end
      ST_CLOSED: begin
        if (open_poll) begin
          state_d  = ST_OPEN;
          counts_d = '0;
          inv_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
      counts_q <= '0;
      inv_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      counts_q <= counts_d;
      inv_q    <= inv_d;
      ack_q    <= ack_d;
    end
  end

  // Lowest index wins among equal maxima; a later strictly larger count clears tie.
  logic [CNT_W-1:0] max_v;
  logic [WIN_W-1:0] win_v;
  logic             tie_v;

  always_comb begin
    max_v = counts_q[CNT_W-1:0];
    win_v = '0;
    tie_v = 1'b0;
    for (int i = 1; i < N_CAND; i++) begin
      if (counts_q[i*CNT_W +: CNT_W] > max_v) begin
        max_v = counts_q[i*CNT_W +: CNT_W];
        win_v = WIN_W'(i);
        tie_v = 1'b0;
      end else if (counts_q[i*CNT_W +: CNT_W] == max_v) begin
        tie_v = 1'b1;
      end
    end
  end

  assign counts      = counts_q;
  assign invalid_cnt = inv_q;
  assign vote_ack    = ack_q;
  assign state       = state_q;
  assign winner      = (state_q == ST_CLOSED) ? win_v : '0;
  assign tie         = (state_q == ST_CLOSED) && tie_v && (max_v != '0);

endmodule

// File: tb/tb_voting_machine_param.sv
// tb/tb_voting_machine_param.sv - directed table-driven bench for voting_machine_param
module tb_voting_machine_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  btn = 3'b000;
  logic        open_poll = 1'b0;
  logic        close_poll = 1'b0;

  logic [23:0] counts;
  logic [7:0]  invalid_cnt;
  logic        vote_ack;
  logic [1:0]  state;
  logic [1:0]  winner;
  logic        tie;

  logic [11:0] counts_s;
  logic [3:0]  invalid_s;
  logic        vote_ack_s;
  logic [1:0]  state_s;
  logic [1:0]  winner_s;
  logic        tie_s;

  voting_machine_param #(.N_CAND(3), .CNT_W(8), .LOCKOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .btn(btn), .open_poll(open_poll), .close_poll(close_poll),
    .counts(counts), .invalid_cnt(invalid_cnt), .vote_ack(vote_ack), .state(state),
    .winner(winner), .tie(tie)
  );

  voting_machine_param #(.N_CAND(3), .CNT_W(4), .LOCKOUT_CYC(4)) dut_s (
    .clk(clk), .rst(rst), .btn(btn), .open_poll(open_poll), .close_poll(close_poll),
    .counts(counts_s), .invalid_cnt(invalid_s), .vote_ack(vote_ack_s), .state(state_s),
    .winner(winner_s), .tie(tie_s)
  );

  always #5 clk = ~clk;

  int ack_tot = 0;
  int ack_tot_s = 0;
  always @(negedge clk) begin
    if (vote_ack) ack_tot = ack_tot + 1;
    if (vote_ack_s) ack_tot_s = ack_tot_s + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(input logic [2:0] m);
    btn = m;
    @(negedge clk);
    btn = 3'b000;
    tick(7);
  endtask

  task automatic pulse(input logic o, input logic c);
    open_poll  = o;
    close_poll = c;
    @(negedge clk);
    open_poll  = 1'b0;
    close_poll = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  localparam int A_PRESS = 0, A_OPEN = 1, A_CLOSE = 2, A_BOTH = 3;

  typedef struct {
    int         act;
    logic [2:0] m;
    int         c0, c1, c2, inv, st, win, tie, acks;
  } vec_t;

  vec_t tbl[16];
  int   base;
  int   exp_lock;

  initial begin
    tbl[0]  = '{A_PRESS, 3'b101, 1, 1, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{A_PRESS, 3'b001, 2, 1, 0, 1, 1, 0, 0, 1};
    tbl[2]  = '{A_PRESS, 3'b010, 2, 2, 0, 1, 1, 0, 0, 1};
    tbl[3]  = '{A_PRESS, 3'b100, 2, 2, 1, 1, 1, 0, 0, 1};
    tbl[4]  = '{A_CLOSE, 3'b000, 2, 2, 1, 1, 2, 0, 1, 0};
    tbl[5]  = '{A_PRESS, 3'b100, 2, 2, 1, 1, 2, 0, 1, 0};
    tbl[6]  = '{A_OPEN,  3'b000, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{A_CLOSE, 3'b000, 0, 0, 0, 0, 2, 0, 0, 0};
    tbl[8]  = '{A_CLOSE, 3'b000, 0, 0, 0, 0, 2, 0, 0, 0};
    tbl[9]  = '{A_OPEN,  3'b000, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{A_PRESS, 3'b010, 0, 1, 0, 0, 1, 0, 0, 1};
    tbl[11] = '{A_OPEN,  3'b000, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{A_PRESS, 3'b110, 0, 1, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{A_PRESS, 3'b100, 0, 1, 1, 1, 1, 0, 0, 1};
    tbl[14] = '{A_PRESS, 3'b100, 0, 1, 2, 1, 1, 0, 0, 1};
    tbl[15] = '{A_BOTH,  3'b000, 0, 1, 2, 1, 2, 2, 0, 0};

    // Reset state
    tick(2);
    chk("rst counts", 64'(counts), 64'd0);
    chk("rst invalid", 64'(invalid_cnt), 64'd0);
    chk("rst state", 64'(state), 64'd0);
    chk("rst ack", 64'(vote_ack), 64'd0);
    chk("rst winner", 64'(winner), 64'd0);
    chk("rst tie", 64'(tie), 64'd0);
    rst = 1'b1;
    tick(1);

    // First vote latency: count lands on the third rising edge with btn high
    pulse(1'b1, 1'b0);
    chk("open state", 64'(state), 64'd1);
    base = ack_tot;
    btn = 3'b001;
    tick(2);
    chk("lat edge2 c0", 64'(counts[7:0]), 64'd0);
    chk("lat edge2 ack", 64'(vote_ack), 64'd0);
    tick(1);
    chk("lat edge3 c0", 64'(counts[7:0]), 64'd1);
    chk("lat edge3 ack", 64'(vote_ack), 64'd1);
    tick(1);
    chk("lat ack pulse end", 64'(vote_ack), 64'd0);
    btn = 3'b000;
    tick(4);
    chk("lat others", 64'(counts[23:8]), 64'd0);

    // Held button counts once
    btn = 3'b010;
    tick(10);
    btn = 3'b000;
    tick(4);
    chk("held c1", 64'(counts[15:8]), 64'd1);
    chk("held acks", 64'(ack_tot - base), 64'd2);

    for (int i = 0; i < 16; i++) begin
      base = ack_tot;
      case (tbl[i].act)
        A_PRESS: do_press(tbl[i].m);
        A_OPEN:  pulse(1'b1, 1'b0);
        A_CLOSE: pulse(1'b0, 1'b1);
        default: pulse(1'b1, 1'b1);
      endcase
      chk($sformatf("row%0d c0", i), 64'(counts[7:0]), 64'(tbl[i].c0));
      chk($sformatf("row%0d c1", i), 64'(counts[15:8]), 64'(tbl[i].c1));
      chk($sformatf("row%0d c2", i), 64'(counts[23:16]), 64'(tbl[i].c2));
      chk($sformatf("row%0d invalid", i), 64'(invalid_cnt), 64'(tbl[i].inv));
      chk($sformatf("row%0d state", i), 64'(state), 64'(tbl[i].st));
      chk($sformatf("row%0d winner", i), 64'(winner), 64'(tbl[i].win));
      chk($sformatf("row%0d tie", i), 64'(tie), 64'(tbl[i].tie));
      chk($sformatf("row%0d acks", i), 64'(ack_tot - base), 64'(tbl[i].acks));
    end

    // Press evaluated in the same cycle as close_poll still counts
    pulse(1'b1, 1'b0);
    btn = 3'b001;
    tick(2);
    close_poll = 1'b1;
    tick(1);
    close_poll = 1'b0;
    btn = 3'b000;
    tick(3);
    chk("close-race state", 64'(state), 64'd2);
    chk("close-race c0", 64'(counts[7:0]), 64'd1);
    chk("close-race winner", 64'(winner), 64'd0);
    chk("close-race tie", 64'(tie), 64'd0);

    // Asynchronous reset mid-session
    pulse(1'b1, 1'b0);
    do_press(3'b001);
    do_press(3'b001);
    do_press(3'b001);
    do_press(3'b010);
    chk("pre-rst counts", 64'(counts), 64'h000103);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst counts", 64'(counts), 64'd0);
    chk("async rst state", 64'(state), 64'd0);
    btn = 3'b010;
    tick(2);
    rst = 1'b1;
    base = ack_tot;
    pulse(1'b1, 1'b0);
    tick(6);
    chk("held-thru-rst c1", 64'(counts[15:8]), 64'd0);
    chk("held-thru-rst acks", 64'(ack_tot - base), 64'd0);
    btn = 3'b000;
    tick(3);
    do_press(3'b010);
    chk("repress c1", 64'(counts[15:8]), 64'd1);

    // Two presses two cycles apart: lockout merges them
    btn = 3'b001;
    tick(1);
    btn = 3'b000;
    tick(1);
    btn = 3'b001;
    tick(1);
    btn = 3'b000;
    tick(10);
`ifdef VOTE_LOCKOUT_EN
    exp_lock = 1;
`else
    exp_lock = 2;
`endif
    chk("lockout c0", 64'(counts[7:0]), 64'(exp_lock));

    // Saturation on the 4-bit instance
    do_reset();
    pulse(1'b1, 1'b0);
    base = ack_tot_s;
    for (int k = 0; k < 17; k++) do_press(3'b010);
    chk("sat c1", 64'(counts_s[7:4]), 64'd15);
    chk("sat acks", 64'(ack_tot_s - base), 64'd17);
    chk("sat wide c1", 64'(counts[15:8]), 64'd17);
    do_press(3'b011);
    chk("sat invalid", 64'(invalid_s), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
